// File: rtl/vadd_pipe_unit_if.sv
`timescale 1ns/1ps
// Handshake bundle for the vector add/sub pipe: operand beat in, result beat out.
interface vadd_pipe_unit_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int SEW_WIDTH   = 2,
   parameter int OPSEL_WIDTH = 5
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_WIDTH-1:0]     vec0;
   logic [DATA_WIDTH-1:0]     vec1;
   logic [DATA_WIDTH/8-1:0]   carry_in;
   logic [SEW_WIDTH-1:0]      sew;
   logic [OPSEL_WIDTH-1:0]    opSel;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_WIDTH-1:0]     result;
   logic [DATA_WIDTH/8-1:0]   carry_out;
   logic                      sat_flag;

   modport master (
      output in_valid, vec0, vec1, carry_in, sew, opSel, out_ready,
      input  in_ready, out_valid, result, carry_out, sat_flag
   );

   modport slave (
      input  in_valid, vec0, vec1, carry_in, sew, opSel, out_ready,
      output in_ready, out_valid, result, carry_out, sat_flag
   );
endinterface

// File: rtl/vadd_pipe_unit.sv
`timescale 1ns/1ps
// Element-partitioned vector add/sub/rsub with carry-in, carry/borrow-out and saturation.
// Latency 2 cycles (S1 partitioned sums, S2 saturation), 1 beat/cycle throughput.
// Backpressure: 2-entry skid; in_ready = ~s1_valid | s2 advancing, outputs held while stalled.
module vadd_pipe_unit #(
   parameter int DATA_WIDTH    = 64,
   parameter int SEW_WIDTH     = 2,
   parameter int OPSEL_WIDTH   = 5,
   parameter int ENABLE_64_BIT = 0
) (
   input logic              clk,
   input logic              rst,
   vadd_pipe_unit_if.slave  bus
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int KW = $clog2(NB);

   logic                  s1_load, s2_load;
   logic                  s1_valid;
   logic [DATA_WIDTH-1:0] s1_sum;
   logic [NB-1:0]         s1_co, s1_ovf, s1_neg;
   logic [1:0]            s1_sew;
   logic                  s1_signed, s1_sat_en, s1_sub;

   logic [1:0]            sew_eff;
   logic                  op_sub, op_rev;
   logic [DATA_WIDTH-1:0] opa, opb, sum_d, res_d;
   logic [NB-1:0]         inject, co_d, ovf_d, neg_d;
   logic                  sat_d;

   assign s2_load     = ~bus.out_valid | bus.out_ready;
   assign s1_load     = ~s1_valid | s2_load;
   assign bus.in_ready = s1_load;

   // Subtraction becomes a + ~b + (1 - c), so the element injection is carry_in XOR sub.
   always_comb begin
      sew_eff = (bus.sew[1:0] == 2'd3 && ENABLE_64_BIT == 0) ? 2'd2 : bus.sew[1:0];
      op_sub  = bus.opSel[1];
      op_rev  = bus.opSel[1] & bus.opSel[0];
      opa     = op_rev ? bus.vec1 : bus.vec0;
      opb     = op_sub ? ~(op_rev ? bus.vec0 : bus.vec1) : bus.vec1;
      inject  = ({NB{bus.opSel[4]}} & bus.carry_in) ^ {NB{op_sub}};
   end

   always_comb begin : s1_adder
      logic          c;
      logic [7:0]    lo;
      logic [1:0]    hi;
      logic [KW-1:0] k;
      int            pos, last;
      sum_d = '0;
      co_d  = '0;
      ovf_d = '0;
      neg_d = '0;
      c     = 1'b0;
      lo    = '0;
      hi    = '0;
      k     = '0;
      pos   = 0;
      last  = (1 << sew_eff) - 1;
      for (int i = 0; i < NB; i++) begin
         pos = i & last;
         k   = KW'(i >> sew_eff);
         if (pos == 0) c = inject[k];
         lo = {1'b0, opa[i*8 +: 7]} + {1'b0, opb[i*8 +: 7]} + {7'd0, c};
         hi = {1'b0, opa[i*8+7]} + {1'b0, opb[i*8+7]} + {1'b0, lo[7]};
         sum_d[i*8 +: 8] = {hi[0], lo[6:0]};
         // Last byte of the element: record carry/borrow, signed overflow and true sign.
         if (pos == last) begin
            co_d[k]  = hi[1] ^ op_sub;
            ovf_d[k] = hi[1] ^ lo[7];
            neg_d[k] = ~hi[0];
         end
         c = hi[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_sum    <= '0;
         s1_co     <= '0;
         s1_ovf    <= '0;
         s1_neg    <= '0;
         s1_sew    <= '0;
         s1_signed <= 1'b0;
         s1_sat_en <= 1'b0;
         s1_sub    <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_sum    <= sum_d;
            s1_co     <= co_d;
            s1_ovf    <= ovf_d;
            s1_neg    <= neg_d;
            s1_sew    <= sew_eff;
            s1_signed <= bus.opSel[2];
            s1_sat_en <= bus.opSel[3] & ~bus.opSel[4];
            s1_sub    <= op_sub;
         end
      end
   end

   // Saturation is applied bytewise: only the element's top byte differs for signed limits.
   always_comb begin : s2_sat
      logic [KW-1:0] k;
      logic          sat_k;
      logic [7:0]    sv;
      int            pos, last;
      res_d = s1_sum;
      sat_d = 1'b0;
      k     = '0;
      sat_k = 1'b0;
      sv    = '0;
      pos   = 0;
      last  = (1 << s1_sew) - 1;
      for (int i = 0; i < NB; i++) begin
         pos   = i & last;
         k     = KW'(i >> s1_sew);
         sat_k = s1_sat_en & (s1_signed ? s1_ovf[k] : s1_co[k]);
         if (s1_signed)
            sv = (pos == last) ? (s1_neg[k] ? 8'h80 : 8'h7F) : (s1_neg[k] ? 8'h00 : 8'hFF);
         else
            sv = s1_sub ? 8'h00 : 8'hFF;
         if (sat_k) begin
            res_d[i*8 +: 8] = sv;
            sat_d           = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         bus.carry_out <= '0;
         bus.sat_flag  <= 1'b0;
      end else if (s2_load) begin
         bus.out_valid <= s1_valid;
         if (s1_valid) begin
            bus.result    <= res_d;
            bus.carry_out <= s1_co;
            bus.sat_flag  <= sat_d;
         end
      end
   end
endmodule

// File: doc/vadd_pipe_unit.md
# vadd_pipe_unit

Pipelined, parametrised successor to the vector ALU add/sub unit. It performs element-partitioned add, subtract and reverse-subtract on a DATA_WIDTH-bit vector word for SEW of 8/16/32/64 bits. Beyond plain add/sub, it supports per-element carry/borrow-in (vadc/vsbc), per-element carry/borrow-out masks (vmadc/vmsbc), and signed/unsigned saturation with a saturation flag. It sits in the vALU lane datapath between operand fetch and writeback, behind a valid/ready handshake.

## Interface
- DATA_WIDTH, 64, vector word width; multiple of 64.
- SEW_WIDTH, 2, width of sew.
- OPSEL_WIDTH, 5, width of opSel.
- ENABLE_64_BIT, 0, 1 enables 64-bit elements; 0 treats sew=11 as 32-bit.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- vec0, vec1  in  DATA_WIDTH  operands.
- carry_in  in  DATA_WIDTH/8  per-element carry/borrow-in; element i uses bit i.
- sew  in  SEW_WIDTH  00=8, 01=16, 10=32, 11=64 bit elements.
- opSel  in  OPSEL_WIDTH  [1:0] 00/01 add, 10 vec0-vec1, 11 vec1-vec0; [2] signed; [3] saturate; [4] use carry_in.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- result  out  DATA_WIDTH  element results.
- carry_out  out  DATA_WIDTH/8  per-element carry (add) or borrow (sub) out; bit i is element i.
- sat_flag  out  1  at least one element of this beat saturated.

## Operation
- Elements per beat: N = DATA_WIDTH/(8<<sew_eff). Element k occupies bits [k*SEW +: SEW].
- Carry chain breaks at every element boundary. There is no propagation between elements.
- Add: a+b+c. Sub: a-b-c. Rsub: b-a-c. Here c = carry_in[k] when opSel[4]=1, else 0.
- Subtraction uses inverted operand plus an injected 1, as in the existing unit.
- carry_out[k] is the raw carry-out for add and the borrow for sub/rsub, computed before saturation. Bits k ≥ N are 0.
- Saturation applies only when opSel[3]=1 and opSel[4]=0. If both are set, opSel[3] is ignored.
  - Unsigned add with carry-out: result is all-ones.
  - Unsigned sub/rsub with borrow: result is 0.
  - Signed overflow: result is max positive or min negative, by the sign of the true result.
- sat_flag is the OR of per-element saturation events. It is 0 when saturation is disabled.
- opSel[2] affects only the saturation decision. The raw sum bits are sign-agnostic.

## Timing
- Two-stage pipeline; latency is 2 cycles, in_valid&in_ready to out_valid.
  - S1 registers the conditioned operands' partitioned sums, per-element carries and overflow bits.
  - S2 registers the saturated result, carry_out and sat_flag.
- Throughput is 1 beat per cycle when out_ready=1.
- Stage advance rules:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 loads when S1 is empty or S2 loads.
  - in_ready = ~S1_valid | S2 loads. in_ready is combinational from out_ready and stage valids.
- A beat is transferred on in_valid&in_ready, and leaves on out_valid&out_ready.
- While out_valid=1 and out_ready=0, result, carry_out and sat_flag are held stable.
- The buffer holds at most 2 beats. With both stages full and out_ready=0, in_ready=0.
- Reset values: out_valid=0, result=0, carry_out=0, sat_flag=0, S1_valid=0. in_ready=1 while rst is low after reset.
- Reset mid-operation:
  - rst asserts asynchronously and discards all in-flight beats.
  - out_valid drops in the same cycle without waiting for a clock edge.
  - Beats are not replayed.
- sew and opSel are captured per beat, so mixed-SEW back-to-back beats are legal.

## Test plan
- Element isolation: sew=00, add, vec0=0x00..00FF, vec1=0x00..0001 -> result=0x0, carry_out=0x01, byte1=0x00 (no ripple), out_valid 2 cycles after accept.
- Signed saturation: sew=10, opSel=01100 (signed, sat, add), element0 0x7FFFFFFF+0x00000001 -> 0x7FFFFFFF, sat_flag=1.
  - Same operands with opSel[3]=0 -> 0x80000000, sat_flag=0.
- Unsigned sub: sew=01, vec0=0x0003, vec1=0x0005, opSel=00010 -> 0xFFFE, carry_out[0]=1.
  - With opSel[3]=1 -> 0x0000, sat_flag=1.
  - Rsub (opSel=00011) -> 0x0002, carry_out[0]=0.
- Carry-in: sew=00, opSel=10000, all bytes 0x10+0x20, carry_in=0xFF -> every byte 0x31.
  - vsbc (opSel=10010) with carry_in=0x01 -> byte0=0xEF, borrow carry_out[0]=1.
- 64-bit mode: sew=11, 0xFFFFFFFF+1.
  - ENABLE_64_BIT=1 -> 0x0000000100000000.
  - ENABLE_64_BIT=0 -> 0x0, carry_out[0]=1.
- Backpressure and reset:
  - Stream 5 beats with out_ready low for 3 cycles -> in_ready=0 once 2 beats are held; all 5 outputs appear in order, no loss or duplication.
  - Assert rst mid-stream -> out_valid=0 immediately; after release, the first new beat emerges with latency 2.
